// File: rtl/pcode_ctrl.sv
// pcode_ctrl
// Sequences one P-code generation job at a time: accepts a job request,
// retunes the external code generator to the requested satellite, paces
// chip requests with a programmable divider, packs the sampled chips into
// WORD_WIDTH-bit words and hands them out through a valid/ready port.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   job request handshake (ready only while idle)
//   cfg_sat               satellite number for the job
//   cfg_num_chips         number of chips to produce (0 = empty job)
//   cfg_clk_div           clock cycles per chip minus one
//   abort                 cancel the running job, discard pending data
//   pc_sat                satellite number driven to the generator
//   pc_prn_changed        tells the generator to reload for pc_sat
//   pc_en                 advance the generator by one chip
//   pc_preg               current chip from the generator
//   word_valid/word_ready output word handshake
//   word_data             packed chips, most recent chip at bit 0
//   word_last             marks the word holding the job's final chip
//   busy                  a job is in progress
//   done                  one-cycle pulse when a job finishes normally
module pcode_ctrl #(
    parameter int SAT_WIDTH      = 6,
    parameter int CHIP_CNT_WIDTH = 24,
    parameter int DIV_WIDTH      = 8,
    parameter int WORD_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [SAT_WIDTH-1:0]      cfg_sat,
    input  logic [CHIP_CNT_WIDTH-1:0] cfg_num_chips,
    input  logic [DIV_WIDTH-1:0]      cfg_clk_div,
    input  logic                      abort,
    output logic [SAT_WIDTH-1:0]      pc_sat,
    output logic                      pc_prn_changed,
    output logic                      pc_en,
    input  logic                      pc_preg,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [WORD_WIDTH-1:0]     word_data,
    output logic                      word_last,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_WIDTH = $clog2(WORD_WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]                rstSync_q;
    logic                      rstInt_n;

    logic [1:0]                state_q,    state_d;
    logic [SAT_WIDTH-1:0]      sat_q,      sat_d;
    logic [CHIP_CNT_WIDTH-1:0] remChips_q, remChips_d;
    logic [DIV_WIDTH-1:0]      clkDiv_q,   clkDiv_d;
    logic [DIV_WIDTH-1:0]      div_q,      div_d;
    logic [WORD_WIDTH-1:0]     asm_q,      asm_d;
    logic [CNT_WIDTH-1:0]      asmCnt_q,   asmCnt_d;
    logic [WORD_WIDTH-1:0]     wordData_q, wordData_d;
    logic                      wordValid_q, wordValid_d;
    logic                      wordLast_q,  wordLast_d;

    logic                      slot;
    logic                      finalChip;
    logic                      completes;
    logic                      outBlocked;
    logic                      accept;
    logic                      abortNow;
    logic [WORD_WIDTH-1:0]     asmNext;

    // Reset asserts immediately but releases only after two clock edges,
    // so no state register leaves reset on a partial clock cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    assign slot       = (state_q == RUN) && (div_q == clkDiv_q);
    assign finalChip  = (remChips_q == CHIP_CNT_WIDTH'(1));
    assign completes  = finalChip || (asmCnt_q == CNT_WIDTH'(WORD_WIDTH - 1));
    // Taking a word-completing chip needs the output register free now.
    assign outBlocked = wordValid_q && !word_ready;
    assign accept     = wordValid_q && word_ready;
    assign abortNow   = abort && (state_q != IDLE);
    assign asmNext    = {asm_q[WORD_WIDTH-2:0], pc_preg};

    // Next-state logic for the job FSM, chip pacing, word assembly and
    // the output register. Abort is applied last so it overrides every
    // other update made in the same cycle.
    always_comb begin
        state_d     = state_q;
        sat_d       = sat_q;
        remChips_d  = remChips_q;
        clkDiv_d    = clkDiv_q;
        div_d       = div_q;
        asm_d       = asm_q;
        asmCnt_d    = asmCnt_q;
        wordData_d  = wordData_q;
        wordValid_d = wordValid_q;
        wordLast_d  = wordLast_q;
        pc_en       = 1'b0;
        done        = 1'b0;

        if (accept) begin
            wordValid_d = 1'b0;
            wordLast_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    sat_d      = cfg_sat;
                    remChips_d = cfg_num_chips;
                    clkDiv_d   = cfg_clk_div;
                    div_d      = '0;
                    asm_d      = '0;
                    asmCnt_d   = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                div_d = '0;
                if (remChips_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (slot) begin
                    if (completes && outBlocked) begin
                        // Park on the slot until the output register frees.
                        div_d = div_q;
                    end else begin
                        pc_en      = 1'b1;
                        div_d      = '0;
                        remChips_d = remChips_q - CHIP_CNT_WIDTH'(1);
                        if (completes) begin
                            wordData_d  = asmNext;
                            wordValid_d = 1'b1;
                            wordLast_d  = finalChip;
                            asm_d       = '0;
                            asmCnt_d    = '0;
                        end else begin
                            asm_d    = asmNext;
                            asmCnt_d = asmCnt_q + CNT_WIDTH'(1);
                        end
                        if (finalChip) begin
                            state_d = FLUSH;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            FLUSH: begin
                // Only the last word can be pending here.
                if (accept) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abortNow) begin
            state_d     = IDLE;
            pc_en       = 1'b0;
            done        = 1'b0;
            remChips_d  = '0;
            div_d       = '0;
            asm_d       = '0;
            asmCnt_d    = '0;
            wordValid_d = 1'b0;
            wordLast_d  = 1'b0;
        end
    end

    // State registers, all cleared by the synchronised internal reset.
    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q     <= IDLE;
            sat_q       <= '0;
            remChips_q  <= '0;
            clkDiv_q    <= '0;
            div_q       <= '0;
            asm_q       <= '0;
            asmCnt_q    <= '0;
            wordData_q  <= '0;
            wordValid_q <= 1'b0;
            wordLast_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sat_q       <= sat_d;
            remChips_q  <= remChips_d;
            clkDiv_q    <= clkDiv_d;
            div_q       <= div_d;
            asm_q       <= asm_d;
            asmCnt_q    <= asmCnt_d;
            wordData_q  <= wordData_d;
            wordValid_q <= wordValid_d;
            wordLast_q  <= wordLast_d;
        end
    end

    assign cfg_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    // The generator reloads when a job starts and when one is abandoned.
    assign pc_prn_changed = (state_q == LOAD) || abortNow;
    assign pc_sat         = sat_q;
    assign word_valid     = wordValid_q;
    assign word_data      = wordData_q;
    assign word_last      = wordLast_q;

endmodule

// File: tb/tb_pcode_ctrl.sv
// tb_pcode_ctrl
// Directed bench for pcode_ctrl. A behavioural chip source feeds pc_preg
// from a fixed pseudo-random sequence indexed by the number of chips taken;
// expected words are computed from that sequence when a job is launched
// and compared against the words the DUT hands out.
module tb_pcode_ctrl;

    localparam int SW  = 6;
    localparam int CCW = 24;
    localparam int DW  = 8;
    localparam int WW  = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [SW-1:0]  cfg_sat = '0;
    logic [CCW-1:0] cfg_num_chips = '0;
    logic [DW-1:0]  cfg_clk_div = '0;
    logic           abort = 1'b0;
    logic [SW-1:0]  pc_sat;
    logic           pc_prn_changed;
    logic           pc_en;
    logic           pc_preg;
    logic           word_valid;
    logic           word_ready = 1'b0;
    logic [WW-1:0]  word_data;
    logic           word_last;
    logic           busy;
    logic           done;

    int checks = 0;
    int failures = 0;

    pcode_ctrl #(
        .SAT_WIDTH(SW), .CHIP_CNT_WIDTH(CCW), .DIV_WIDTH(DW), .WORD_WIDTH(WW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sat(cfg_sat), .cfg_num_chips(cfg_num_chips), .cfg_clk_div(cfg_clk_div),
        .abort(abort),
        .pc_sat(pc_sat), .pc_prn_changed(pc_prn_changed), .pc_en(pc_en), .pc_preg(pc_preg),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_last(word_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic refBit(input int i);
        logic [31:0] x;
        x = 32'(i) * 32'h9E3779B1;
        return x[19] ^ x[7];
    endfunction

    // Chip source: advances one position per chip taken.
    int enTotal = 0;
    always @(posedge clk) begin
        if (pc_en) enTotal <= enTotal + 1;
    end
    assign pc_preg = refBit(enTotal);

    // Monitor: records pulses, accepted words and stall stability at negedge.
    int cyc = 0, enPulses = 0, donePulses = 0, prnPulses = 0, validCycles = 0, stallErr = 0;
    int enCycles[$];
    logic [WW-1:0] obsData[$];
    logic          obsLast[$];
    logic          prevHold = 1'b0;
    logic [WW-1:0] prevData = '0;
    logic          prevLast = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (pc_en) begin
            enPulses++;
            enCycles.push_back(cyc);
        end
        if (done) donePulses++;
        if (pc_prn_changed) prnPulses++;
        if (word_valid) validCycles++;
        if (prevHold && reset_n && (!word_valid || word_data !== prevData || word_last !== prevLast))
            stallErr++;
        if (word_valid && word_ready) begin
            obsData.push_back(word_data);
            obsLast.push_back(word_last);
        end
        prevHold = reset_n && word_valid && !word_ready && !abort;
        prevData = word_data;
        prevLast = word_last;
    end

    // Scoreboard of expected words.
    logic [WW-1:0] expData[$];
    logic          expLast[$];
    int obsRd = 0;
    int expRd = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectJob(input int n, input int base);
        logic [WW-1:0] w;
        int cnt;
        w = '0;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            w = {w[WW-2:0], refBit(base + k)};
            cnt++;
            if (cnt == WW || k == n - 1) begin
                expData.push_back(w);
                expLast.push_back(k == n - 1);
                w = '0;
                cnt = 0;
            end
        end
    endtask

    // Launches a job and leaves the bench 1 time unit into the LOAD cycle.
    task automatic applyStimulus(input int sat, input int n, input int div);
        int t;
        int base;
        t = 0;
        while (!cfg_ready && t < 200) begin
            tick();
            t++;
        end
        checkOutput("cfgReadyBeforeJob", 64'(cfg_ready), 64'd1);
        cfg_sat       = SW'(sat);
        cfg_num_chips = CCW'(n);
        cfg_clk_div   = DW'(div);
        cfg_valid     = 1'b1;
        @(posedge clk);
        #1;
        base = enTotal;
        cfg_valid = 1'b0;
        expectJob(n, base);
    endtask

    task automatic waitDone(input int d0, input int limit);
        int t;
        t = 0;
        while (donePulses == d0 && t < limit) begin
            tick();
            t++;
        end
        repeat (5) tick();
    endtask

    task automatic compareWords(input string tag);
        checkOutput({tag, "_count"}, 64'(obsData.size() - obsRd), 64'(expData.size() - expRd));
        while (obsRd < obsData.size() && expRd < expData.size()) begin
            checkOutput({tag, "_data"}, 64'(obsData[obsRd]), 64'(expData[expRd]));
            checkOutput({tag, "_last"}, 64'(obsLast[obsRd]), 64'(expLast[expRd]));
            obsRd++;
            expRd++;
        end
        obsRd = obsData.size();
        expRd = expData.size();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, e0, i0, p0, v0, s0, bad, span;

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("rst_busy_done_en_prn", 64'({busy, done, pc_en, pc_prn_changed}), 64'd0);
        checkOutput("rst_pc_sat", 64'(pc_sat), 64'd0);
        checkOutput("rst_word", 64'({word_valid, word_last, word_data}), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // 64 chips, divider 0, sink always ready.
        $display("[TB] job: 64 chips, clk_div 0");
        word_ready = 1'b1;
        d0 = donePulses; e0 = enPulses; i0 = enCycles.size(); p0 = prnPulses;
        applyStimulus(5, 64, 0);
        @(negedge clk);
        checkOutput("a_prn_in_load", 64'(pc_prn_changed), 64'd1);
        checkOutput("a_pc_sat", 64'(pc_sat), 64'd5);
        checkOutput("a_busy_ready", 64'({busy, cfg_ready}), 64'b10);
        waitDone(d0, 300);
        checkOutput("a_en_pulses", 64'(enPulses - e0), 64'd64);
        span = (enCycles.size() >= i0 + 64) ? enCycles[i0 + 63] - enCycles[i0] : -1;
        checkOutput("a_en_consecutive", 64'(span), 64'd63);
        compareWords("a_word");
        checkOutput("a_done_once", 64'(donePulses - d0), 64'd1);
        checkOutput("a_prn_once", 64'(prnPulses - p0), 64'd1);
        checkOutput("a_idle_after", 64'({cfg_ready, busy}), 64'b10);

        // 8 chips, divider 3: one chip every 4 cycles, one partial word.
        $display("[TB] job: 8 chips, clk_div 3");
        d0 = donePulses; e0 = enPulses; i0 = enCycles.size();
        applyStimulus(9, 8, 3);
        waitDone(d0, 300);
        checkOutput("b_en_pulses", 64'(enPulses - e0), 64'd8);
        bad = 0;
        for (int j = i0 + 1; j < enCycles.size(); j++) begin
            if (enCycles[j] - enCycles[j - 1] != 4) bad++;
        end
        checkOutput("b_en_period", 64'(bad), 64'd0);
        if (obsData.size() > obsRd)
            checkOutput("b_upper_zero", 64'(obsData[obsRd][WW-1:8]), 64'd0);
        compareWords("b_word");
        checkOutput("b_done_once", 64'(donePulses - d0), 64'd1);

        // 96 chips with the sink stalled: expect a stall after 63 chips.
        $display("[TB] job: 96 chips, sink stalled");
        word_ready = 1'b0;
        d0 = donePulses; e0 = enPulses; s0 = stallErr;
        applyStimulus(17, 96, 0);
        repeat (100) tick();
        checkOutput("c_en_stalled", 64'(enPulses - e0), 64'd63);
        checkOutput("c_valid_held", 64'(word_valid), 64'd1);
        checkOutput("c_stable", 64'(stallErr - s0), 64'd0);
        word_ready = 1'b1;
        waitDone(d0, 300);
        checkOutput("c_en_total", 64'(enPulses - e0), 64'd96);
        compareWords("c_word");
        checkOutput("c_done_once", 64'(donePulses - d0), 64'd1);

        // Empty job.
        $display("[TB] job: 0 chips");
        d0 = donePulses; e0 = enPulses; v0 = validCycles;
        applyStimulus(3, 0, 2);
        @(negedge clk);
        checkOutput("d_load_done_prn", 64'({done, pc_prn_changed}), 64'b11);
        repeat (5) tick();
        checkOutput("d_no_en", 64'(enPulses - e0), 64'd0);
        checkOutput("d_no_valid", 64'(validCycles - v0), 64'd0);
        checkOutput("d_done_once", 64'(donePulses - d0), 64'd1);
        checkOutput("d_idle", 64'(cfg_ready), 64'd1);
        compareWords("d_word");

        // Abort after 20 chips.
        $display("[TB] job: abort at chip 20");
        d0 = donePulses; e0 = enPulses;
        applyStimulus(21, 64, 0);
        bad = 0;
        while (enPulses - e0 < 20 && bad < 100) begin
            tick();
            bad++;
        end
        checkOutput("e_reached_20", 64'(enPulses - e0), 64'd20);
        p0 = prnPulses;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("e_prn_on_abort", 64'(pc_prn_changed), 64'd1);
        checkOutput("e_no_en_on_abort", 64'(pc_en), 64'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("e_idle_next", 64'({cfg_ready, busy, word_valid, pc_prn_changed}), 64'b1000);
        e0 = enPulses;
        repeat (10) tick();
        checkOutput("e_no_done", 64'(donePulses - d0), 64'd0);
        checkOutput("e_prn_once", 64'(prnPulses - p0), 64'd1);
        checkOutput("e_en_stopped", 64'(enPulses - e0), 64'd0);
        checkOutput("e_no_words", 64'(obsData.size() - obsRd), 64'd0);
        expRd = expData.size();

        // Reset in the middle of a stalled job, then a fresh job.
        $display("[TB] job: reset mid-run");
        word_ready = 1'b0;
        applyStimulus(30, 64, 1);
        repeat (80) tick();
        checkOutput("f_valid_pending", 64'(word_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("f_rst_ready_busy", 64'({cfg_ready, busy}), 64'b10);
        checkOutput("f_rst_ctrl", 64'({done, pc_en, pc_prn_changed}), 64'd0);
        checkOutput("f_rst_pc_sat", 64'(pc_sat), 64'd0);
        checkOutput("f_rst_word", 64'({word_valid, word_last, word_data}), 64'd0);
        obsRd = obsData.size();
        expRd = expData.size();
        repeat (3) tick();
        reset_n = 1'b1;
        word_ready = 1'b1;
        repeat (4) tick();
        d0 = donePulses; e0 = enPulses;
        applyStimulus(31, 40, 0);
        waitDone(d0, 300);
        checkOutput("f_en_pulses", 64'(enPulses - e0), 64'd40);
        compareWords("f_word");
        checkOutput("f_done_once", 64'(donePulses - d0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
